// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants: status bit positions, default sizes, status packing.
package uart_pkg;

    localparam int RX_READY  = 0;
    localparam int FULL      = 1;
    localparam int OVERRUN   = 2;
    localparam int FRAME_ERR = 3;
    localparam int TIMEOUT   = 4;

    localparam int DEFAULT_DEPTH       = 16;
    localparam int DEFAULT_ADDR_W      = 4;
    localparam int DEFAULT_SYNC_STAGES = 2;
    localparam int DEFAULT_TIMEOUT     = 2560;

    function automatic logic [7:0] pack_status(
        input logic rx_ready,
        input logic full,
        input logic overrun,
        input logic frame_err,
        input logic timeout
    );
        logic [7:0] s;
        s            = 8'h00;
        s[RX_READY]  = rx_ready;
        s[FULL]      = full;
        s[OVERRUN]   = overrun;
        s[FRAME_ERR] = frame_err;
        s[TIMEOUT]   = timeout;
        return s;
    endfunction

endpackage

// File: rtl/strobe_sync_edge.sv
// rtl/strobe_sync_edge.sv - synchronizes an asynchronous strobe and emits a one-clock pulse on its falling edge.
module strobe_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_fall_pulse
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    // History clears to 0 so a strobe that was high across reset cannot look like a falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q[0] <= i_async;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign o_fall_pulse = hist_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive FIFO with CPU read pop, sticky error flags and IRQ.
// Optional idle timeout flag enabled by defining UART_RX_FIFO_TIMEOUT_EN.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
`ifdef UART_RX_FIFO_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    input  logic              i_rx_frame_err,
    input  logic              i_rd_strobe,
    input  logic              i_clr_errors,
    input  logic              i_irq_en,
    output logic [7:0]        o_rd_data,
    output logic [7:0]        o_status,
    output logic [ADDR_W:0]   o_count,
    output logic              o_irq
);

    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overrun_q, overrun_d;
    logic              frame_err_q, frame_err_d;
    logic              irq_q;
    logic              timeout_q;

    logic              pop_pulse;
    logic              empty;
    logic              full;
    logic              accept;
    logic              do_push;
    logic              do_pop;

    strobe_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_rd_sync (
        .clk          (clk),
        .reset        (reset),
        .i_async      (i_rd_strobe),
        .o_fall_pulse (pop_pulse)
    );

    assign empty  = (count_q == '0);
    assign full   = (count_q == FULL_COUNT);
    assign accept = i_rx_valid && !i_rx_frame_err;
    assign do_pop = pop_pulse && !empty;
    // A pop in the same clock frees a slot, so a push into a full FIFO still lands.
    assign do_push = accept && (!full || do_pop);

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;

        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (i_clr_errors) begin
            overrun_d   = 1'b0;
            frame_err_d = 1'b0;
        end
        if (accept && full && !do_pop) begin
            overrun_d = 1'b1;
        end
        if (i_rx_valid && i_rx_frame_err) begin
            frame_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= i_rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            irq_q       <= i_irq_en && (!empty || overrun_q || timeout_q);
        end
    end

`ifdef UART_RX_FIFO_TIMEOUT_EN
    localparam int                IDLE_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_ONE = IDLE_W'(1);

    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              timeout_d;

    // Counter saturates at the limit so the flag keeps re-asserting until the FIFO is serviced.
    always_comb begin
        idle_d    = idle_q;
        timeout_d = timeout_q;
        if (do_push || do_pop || count_d == '0) begin
            idle_d = '0;
        end else if (!empty && idle_q != IDLE_MAX) begin
            idle_d = idle_q + IDLE_ONE;
        end
        if (i_clr_errors) begin
            timeout_d = 1'b0;
        end
        if (idle_q == IDLE_MAX) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            idle_q    <= idle_d;
            timeout_q <= timeout_d;
        end
    end
`else
    assign timeout_q = 1'b0;
`endif

    assign o_rd_data = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign o_status  = pack_status(!empty, full, overrun_q, frame_err_q, timeout_q);
    assign o_count   = count_q;
    assign o_irq     = irq_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo.
module tb_uart_rx_fifo;

    localparam int SYNC = 2;

    logic       clk;
    logic       reset;
    logic [7:0] i_rx_data;
    logic       i_rx_valid;
    logic       i_rx_frame_err;
    logic       i_rd_strobe;
    logic       i_clr_errors;
    logic       i_irq_en;
    logic [7:0] o_rd_data;
    logic [7:0] o_status;
    logic [4:0] o_count;
    logic       o_irq;

    int n_checks = 0;
    int n_fail   = 0;

    uart_rx_fifo dut (
        .clk            (clk),
        .reset          (reset),
        .i_rx_data      (i_rx_data),
        .i_rx_valid     (i_rx_valid),
        .i_rx_frame_err (i_rx_frame_err),
        .i_rd_strobe    (i_rd_strobe),
        .i_clr_errors   (i_clr_errors),
        .i_irq_en       (i_irq_en),
        .o_rd_data      (o_rd_data),
        .o_status       (o_status),
        .o_count        (o_count),
        .o_irq          (o_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic ferr);
        i_rx_data      = d;
        i_rx_frame_err = ferr;
        i_rx_valid     = 1'b1;
        tick();
        i_rx_valid     = 1'b0;
        i_rx_frame_err = 1'b0;
    endtask

    task automatic clr_errors();
        i_clr_errors = 1'b1;
        tick();
        i_clr_errors = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic read_byte(input string tag, input logic [7:0] exp);
        check({tag, "_pre"}, 32'(o_rd_data), 32'(exp));
        i_rd_strobe = 1'b1;
        repeat (8) tick();
        check({tag, "_e_high"}, 32'(o_rd_data), 32'(exp));
        i_rd_strobe = 1'b0;
        repeat (SYNC + 2) tick();
    endtask

    // Strobe falls, then push is timed to coincide with the resulting pop pulse.
    task automatic push_with_pop(input logic [7:0] d);
        i_rd_strobe = 1'b1;
        repeat (8) tick();
        i_rd_strobe = 1'b0;
        repeat (SYNC) tick();
        push(d, 1'b0);
    endtask

    initial begin
        reset          = 1'b1;
        i_rx_data      = 8'h00;
        i_rx_valid     = 1'b0;
        i_rx_frame_err = 1'b0;
        i_rd_strobe    = 1'b0;
        i_clr_errors   = 1'b0;
        i_irq_en       = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        check("rst_count",  32'(o_count),   'h0);
        check("rst_status", 32'(o_status),  'h0);
        check("rst_rddata", 32'(o_rd_data), 'h0);
        check("rst_irq",    32'(o_irq),     'h0);

        // Reset mid-operation with the read strobe held high throughout.
        for (int i = 0; i < 5; i++) push(8'(8'h30 + i), 1'b0);
        tick();
        check("mid_count", 32'(o_count), 'h5);
        check("mid_irq",   32'(o_irq),   'h1);
        i_rd_strobe = 1'b1;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset       = 1'b0;
        i_rd_strobe = 1'b0;
        check("mr_count",  32'(o_count),  'h0);
        check("mr_status", 32'(o_status), 'h0);
        check("mr_irq",    32'(o_irq),    'h0);
        push(8'h61, 1'b0);
        repeat (6) tick();
        check("mr_no_pop", 32'(o_count), 'h1);
        do_reset();

        // Basic push then three reads.
        push(8'h41, 1'b0);
        push(8'h42, 1'b0);
        push(8'h43, 1'b0);
        tick();
        check("b_count",  32'(o_count),  'h3);
        check("b_status", 32'(o_status), 'h01);
        check("b_irq",    32'(o_irq),    'h1);
        read_byte("b_rd41", 8'h41);
        read_byte("b_rd42", 8'h42);
        read_byte("b_rd43", 8'h43);
        check("b_empty_data", 32'(o_rd_data), 'h0);
        check("b_empty_cnt",  32'(o_count),   'h0);
        check("b_irq_off",    32'(o_irq),     'h0);

        // Fill, overrun, clear.
        for (int i = 0; i < 16; i++) push(8'(8'h10 + i), 1'b0);
        check("f_count",  32'(o_count),  'h10);
        check("f_status", 32'(o_status), 'h03);
        push(8'hFF, 1'b0);
        check("ovr_status", 32'(o_status),  'h07);
        check("ovr_count",  32'(o_count),   'h10);
        check("ovr_head",   32'(o_rd_data), 'h10);
        clr_errors();
        check("clr_status", 32'(o_status), 'h03);

        // Full: push and pop in the same clock.
        push_with_pop(8'hAA);
        check("fpp_count",  32'(o_count),   'h10);
        check("fpp_status", 32'(o_status),  'h03);
        check("fpp_head",   32'(o_rd_data), 'h11);
        for (int i = 1; i < 16; i++) read_byte($sformatf("drain%0d", i), 8'(8'h10 + i));
        read_byte("drain_aa", 8'hAA);
        check("drain_count", 32'(o_count), 'h0);

        // Frame error and read of an empty FIFO.
        push(8'h55, 1'b1);
        check("fe_count",  32'(o_count),  'h0);
        check("fe_status", 32'(o_status), 'h08);
        read_byte("fe_empty_rd", 8'h00);
        check("under_count", 32'(o_count), 'h0);
        clr_errors();
        check("fe_clr", 32'(o_status), 'h00);

        // Empty: push and pop in the same clock keeps the byte.
        push_with_pop(8'h5A);
        check("epp_count", 32'(o_count),   'h1);
        check("epp_head",  32'(o_rd_data), 'h5A);
        read_byte("epp_rd", 8'h5A);
        check("epp_after", 32'(o_count), 'h0);

`ifdef UART_RX_FIFO_TIMEOUT_EN
        push(8'h77, 1'b0);
        repeat (2500) tick();
        check("to_early", 32'(o_status[4]), 'h0);
        repeat (100) tick();
        check("to_set", 32'(o_status[4]), 'h1);
        check("to_irq", 32'(o_irq),       'h1);
        read_byte("to_rd", 8'h77);
        check("to_sticky",    32'(o_status), 'h10);
        check("to_irq_stays", 32'(o_irq),    'h1);
        clr_errors();
        tick();
        check("to_clr",     32'(o_status), 'h00);
        check("to_irq_clr", 32'(o_irq),    'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer between the UART bit deserializer (upstream, clk domain) and the 6809 data/status register logic in uart_interface (downstream).
- Queues received bytes and presents the head byte and a status byte for CPU reads.
- Pops exactly once per completed 6809 read of the UART data address.
- Raises an interrupt request while data is waiting.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2.
ADDR_W, 4, log2(DEPTH).
SYNC_STAGES, 2, flip-flop stages used to synchronize the asynchronous CPU read strobe.
TIMEOUT_CYCLES, 2560, idle clocks before the timeout flag sets (optional feature only).

Ports:
clk  in  1  8 MHz system clock (PLL CLKOS).
reset  in  1  Synchronous, active-high reset.
i_rx_data  in  8  Byte from the deserializer.
i_rx_valid  in  1  Single-cycle push strobe for i_rx_data.
i_rx_frame_err  in  1  Qualifies i_rx_valid; the byte carried a bad stop bit.
i_rd_strobe  in  1  Asynchronous CPU data read: uart_data_ce && i_RW && E.
i_clr_errors  in  1  Single-cycle pulse from a control register write; clears sticky flags.
i_irq_en  in  1  Interrupt enable, from the control register.
o_rd_data  out  8  Head byte; 8'h00 when empty.
o_status  out  8  Status byte (see Behaviour).
o_count  out  ADDR_W+1  Current occupancy, 0..DEPTH.
o_irq  out  1  Active-high interrupt request; inverted to active-low at top level.

Behaviour:
- Reset (synchronous, active-high) clears:
  - rd_ptr, wr_ptr and count to 0.
  - All sticky flags.
  - Synchronizer and edge-detect history to 0, so no spurious pop follows reset.
  - Output values after reset: o_rd_data=8'h00, o_status=8'h00, o_count=0, o_irq=0.
  - Memory contents need no reset.
- Push, when i_rx_valid=1:
  - i_rx_frame_err=1: byte discarded; frame_err flag set.
  - Else if not full: byte written at wr_ptr; wr_ptr increments and wraps modulo DEPTH.
  - Else (full): byte discarded; overrun flag set; FIFO contents unchanged.
- Pop path:
  - i_rd_strobe passes through a SYNC_STAGES flip-flop synchronizer.
  - A falling edge of the synchronized strobe produces a one-clock pop pulse, SYNC_STAGES+1 clocks after the strobe deasserts.
  - Popping at the end of the bus cycle keeps o_rd_data stable for the whole E-high window.
  - Pop when empty is ignored: no underflow, pointers unchanged.
- Simultaneous push and pop in the same clock:
  - Both take effect; count is unchanged.
  - When full, the push is accepted because a slot frees in that cycle; overrun is not set.
  - When empty, the push is accepted and the pop is ignored; count becomes 1.
- o_rd_data = mem[rd_ptr] when count != 0, else 8'h00.
  - Reflects a new head combinationally from the pointer and count registers in the clock after a push or pop.
- o_status bits:
  - [0] rx_ready (count != 0)
  - [1] full
  - [2] overrun
  - [3] frame_err
  - [4] timeout (0 if feature absent)
  - [7:5] = 0
- i_clr_errors clears bits [2], [3] and [4]. A set event in the same cycle as a clear wins.
- o_irq is registered: i_irq_en && (rx_ready || overrun || timeout), one clock latency.
- The 6809 at 1 MHz E gives at least 8 clk periods between strobes; back-to-back pops one clock apart are still handled correctly.

Optional Feature:
Macro UART_RX_FIFO_TIMEOUT_EN.
- Defined:
  - An idle counter resets on every push or pop and counts while count != 0.
  - When it reaches TIMEOUT_CYCLES, the timeout flag sets (sticky) and the counter holds.
  - The counter clears when the FIFO empties.
- Undefined: no counter is synthesized, status bit [4] is tied to 0, and timeout does not contribute to o_irq.

Decomposition:
- Package uart_pkg:
  - Status bit index constants: RX_READY=0, FULL=1, OVERRUN=2, FRAME_ERR=3, TIMEOUT=4.
  - Default depth and timeout constants.
- Sub-module strobe_sync_edge: parameter STAGES; ports clk, reset, i_async, o_fall_pulse. It is reused later for the SPI and SRAM strobes.
- FIFO storage and pointer logic stay inline.

Test Plan:
1. Reset mid-operation: 5 bytes queued, then assert reset for 1 clock -> o_count=0, o_status=8'h00, o_irq=0; no pop is generated by a strobe that was high during reset.
2. Push 8'h41, 8'h42, 8'h43 with i_irq_en=1 -> o_count=3, o_rd_data=8'h41, o_status=8'h01, o_irq=1. Three read strobes -> reads 41, 42, 43, then o_rd_data=8'h00 and o_irq=0.
3. Fill with 16 bytes, push 8'hFF -> o_status=8'h07, byte dropped; i_clr_errors -> o_status=8'h03.
4. FIFO full: push and pop in the same clock -> o_count stays 16, overrun=0, new byte read last.
5. Push with i_rx_frame_err=1 -> o_count unchanged, status bit 3=1. Read strobe on empty FIFO -> o_count stays 0.
6. With UART_RX_FIFO_TIMEOUT_EN: 1 byte, idle 2560 clocks -> status bit 4=1, o_irq=1. Pop -> FIFO empty; bit 4 stays 1 (sticky), so o_irq stays 1 until i_clr_errors.
